vram_scan_wb: RTL and testbench

//  Parametrised 32-bit dual-port framebuffer RAM for the Zucker GPU. Port A is a Wishbone

---
 rtl/vram_scan_wb.sv | 208 ++++++++++++++++++++
 tb/tb_vram_scan_wb.sv | 243 ++++++++++++++++++++++++
 2 files changed

// File: rtl/vram_scan_wb.sv
// Framebuffer RAM: Wishbone slave on port A, prefetching pixel scanout engine on port B.
// Optional 2x2 pixel doubling via horizontal repeat and per-line refetch.
module vram_scan_wb #(
   parameter int unsigned ADDR_W       = 15,
   parameter int unsigned DEPTH        = 24576,
   parameter int unsigned BPP          = 1,
   parameter int unsigned H_PIXELS     = 1024,
   parameter int unsigned V_LINES      = 768,
   parameter int unsigned PIXEL_DOUBLE = 0,
   parameter int unsigned FIFO_DEPTH   = 4
) (
   input  logic              wb_clk_i,
   input  logic              wb_rst_i,
   input  logic [ADDR_W-1:0] wb_adr_i,
   input  logic [31:0]       wb_dat_i,
   output logic [31:0]       wb_dat_o,
   input  logic              wb_we_i,
   input  logic [3:0]        wb_sel_i,
   input  logic              wb_stb_i,
   input  logic              wb_cyc_i,
   output logic              wb_ack_o,
   input  logic [ADDR_W-1:0] fb_base_i,
   input  logic              frame_start_i,
   input  logic              pix_req_i,
   output logic [BPP-1:0]    pix_o,
   output logic              underrun_o
);
   localparam int unsigned PPW    = 32 / BPP;
   localparam int unsigned WPL    = (PIXEL_DOUBLE != 0) ? (H_PIXELS * BPP / 64) : (H_PIXELS * BPP / 32);
   localparam int unsigned TOTAL  = V_LINES * WPL;
   localparam int unsigned CNT_W  = $clog2(TOTAL + 1);
   localparam int unsigned WIL_W  = (WPL > 1) ? $clog2(WPL) : 1;
   localparam int unsigned PIX_W  = (PPW > 1) ? $clog2(PPW) : 1;
   localparam int unsigned PTR_W  = $clog2(FIFO_DEPTH);
   localparam int unsigned FCNT_W = PTR_W + 1;
   localparam int unsigned MEM_AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

   logic [31:0] mem [DEPTH];

   // Fetch engine state
   logic              active;
   logic [ADDR_W-1:0] fetch_addr;
   logic [ADDR_W-1:0] line_start;
   logic [WIL_W-1:0]  word_in_line;
   logic              second_pass;
   logic [CNT_W-1:0]  fetch_cnt;
   logic              rd_vld;
   logic [CNT_W-1:0]  rd_idx;
   logic [31:0]       ram_q;

   // Prefetch FIFO and serializer state
   logic [31:0]       fifo_mem [FIFO_DEPTH];
   logic [PTR_W-1:0]  rd_ptr;
   logic [PTR_W-1:0]  wr_ptr;
   logic [FCNT_W-1:0] fifo_count;
   logic [PIX_W-1:0]  pix_idx;
   logic              rep;
   logic [CNT_W-1:0]  cons_idx;

   logic              wb_hit_c;
   logic              wb_in_rng_c;
   logic [MEM_AW-1:0] wb_idx_c;
   logic              fetch_in_rng_c;
   logic [MEM_AW-1:0] fetch_idx_c;
   logic              issue_c;
   logic              line_end_c;
   logic              fifo_empty_c;
   logic [31:0]       head_c;
   logic [BPP-1:0]    pix_sel_c;
   logic              in_frame_c;
   logic              rep_done_c;
   logic              word_end_c;
   logic              cons_adv_c;
   logic [CNT_W-1:0]  cons_nxt_c;
   logic              pop_c;
   logic              push_c;

   function automatic logic [ADDR_W-1:0] addr_inc(input logic [ADDR_W-1:0] a);
      return ({1'b0, a} == (ADDR_W + 1)'(DEPTH - 1)) ? '0 : a + ADDR_W'(1);
   endfunction

   assign wb_hit_c       = wb_cyc_i & wb_stb_i & ~wb_ack_o;
   assign wb_in_rng_c    = {1'b0, wb_adr_i} < (ADDR_W + 1)'(DEPTH);
   assign wb_idx_c       = wb_adr_i[MEM_AW-1:0];
   assign fetch_in_rng_c = {1'b0, fetch_addr} < (ADDR_W + 1)'(DEPTH);
   assign fetch_idx_c    = fetch_addr[MEM_AW-1:0];

   assign issue_c    = active & ~frame_start_i & (fetch_cnt < CNT_W'(TOTAL)) &
                       ((32'(fifo_count) + 32'(rd_vld)) < FIFO_DEPTH);
   assign line_end_c = (word_in_line == WIL_W'(WPL - 1));

   assign fifo_empty_c = (fifo_count == '0);
   assign head_c       = fifo_mem[rd_ptr];
   assign pix_sel_c    = BPP'(head_c >> (32'(pix_idx) * BPP));
   assign in_frame_c   = (cons_idx < CNT_W'(TOTAL));
   assign rep_done_c   = (PIXEL_DOUBLE == 0) || rep;
   assign word_end_c   = (pix_idx == PIX_W'(PPW - 1));
   assign cons_adv_c   = pix_req_i & ~frame_start_i & in_frame_c & rep_done_c & word_end_c;
   assign cons_nxt_c   = cons_idx + CNT_W'(cons_adv_c);
   assign pop_c        = cons_adv_c & ~fifo_empty_c;
   // Words the serializer already skipped past during an underrun are dropped to keep alignment
   assign push_c       = rd_vld & ~frame_start_i & (rd_idx >= cons_nxt_c);

   // RAM array: byte-lane writes from Wishbone, scanout read port sees pre-write data
   always_ff @(posedge wb_clk_i) begin
      if (wb_hit_c && wb_we_i && wb_in_rng_c) begin
         for (int n = 0; n < 4; n++) begin
            if (wb_sel_i[n]) mem[wb_idx_c][8*n +: 8] <= wb_dat_i[8*n +: 8];
         end
      end
      if (issue_c) ram_q <= fetch_in_rng_c ? mem[fetch_idx_c] : '0;
   end

   always_ff @(posedge wb_clk_i) begin
      if (wb_rst_i) begin
         wb_ack_o <= 1'b0;
         wb_dat_o <= '0;
      end else begin
         wb_ack_o <= wb_hit_c;
         if (wb_hit_c) wb_dat_o <= wb_in_rng_c ? mem[wb_idx_c] : '0;
      end
   end

   // Fetch address generation with optional line rewind for vertical doubling
   always_ff @(posedge wb_clk_i) begin
      if (wb_rst_i) begin
         active       <= 1'b0;
         fetch_addr   <= '0;
         line_start   <= '0;
         word_in_line <= '0;
         second_pass  <= 1'b0;
         fetch_cnt    <= '0;
         rd_vld       <= 1'b0;
         rd_idx       <= '0;
      end else if (frame_start_i) begin
         active       <= 1'b1;
         fetch_addr   <= fb_base_i;
         line_start   <= fb_base_i;
         word_in_line <= '0;
         second_pass  <= 1'b0;
         fetch_cnt    <= '0;
         rd_vld       <= 1'b0;
      end else begin
         rd_vld <= issue_c;
         if (issue_c) begin
            rd_idx    <= fetch_cnt;
            fetch_cnt <= fetch_cnt + CNT_W'(1);
            if (line_end_c) begin
               word_in_line <= '0;
               if ((PIXEL_DOUBLE != 0) && !second_pass) begin
                  second_pass <= 1'b1;
                  fetch_addr  <= line_start;
               end else begin
                  second_pass <= 1'b0;
                  fetch_addr  <= addr_inc(fetch_addr);
                  line_start  <= addr_inc(fetch_addr);
               end
            end else begin
               word_in_line <= word_in_line + WIL_W'(1);
               fetch_addr   <= addr_inc(fetch_addr);
            end
         end
      end
   end

   always_ff @(posedge wb_clk_i) begin
      if (push_c) fifo_mem[wr_ptr] <= ram_q;
   end

   always_ff @(posedge wb_clk_i) begin
      if (wb_rst_i || frame_start_i) begin
         rd_ptr     <= '0;
         wr_ptr     <= '0;
         fifo_count <= '0;
      end else begin
         if (push_c) wr_ptr <= wr_ptr + PTR_W'(1);
         if (pop_c)  rd_ptr <= rd_ptr + PTR_W'(1);
         fifo_count <= fifo_count + FCNT_W'(push_c) - FCNT_W'(pop_c);
      end
   end

   // Serializer: head word stays in the FIFO until its last pixel is shown
   always_ff @(posedge wb_clk_i) begin
      if (wb_rst_i || frame_start_i) begin
         pix_idx    <= '0;
         rep        <= 1'b0;
         cons_idx   <= '0;
         pix_o      <= '0;
         underrun_o <= 1'b0;
      end else if (pix_req_i) begin
         if (!in_frame_c || fifo_empty_c) begin
            pix_o      <= '0;
            underrun_o <= 1'b1;
         end else begin
            pix_o <= pix_sel_c;
         end
         if (in_frame_c) begin
            if (!rep_done_c) begin
               rep <= 1'b1;
            end else begin
               rep     <= 1'b0;
               pix_idx <= word_end_c ? '0 : pix_idx + PIX_W'(1);
            end
            cons_idx <= cons_nxt_c;
         end
      end
   end
endmodule

// File: tb/tb_vram_scan_wb.sv
// Bench for vram_scan_wb: Wishbone vector table, random RMW against a RAM model,
// and scanout frames checked against a pixel-position model of the framebuffer.
module tb_vram_scan_wb;
   localparam int unsigned ADDR_W       = 8;
   localparam int unsigned DEPTH        = 200;
   localparam int unsigned BPP          = 2;
   localparam int unsigned H_PIXELS     = 64;
   localparam int unsigned V_LINES      = 4;
   localparam int unsigned PIXEL_DOUBLE = 1;
   localparam int unsigned FIFO_DEPTH   = 4;
   localparam int unsigned PPW          = 32 / BPP;
   localparam int unsigned WPL          = H_PIXELS * BPP / 64;
   localparam int unsigned NPIX         = H_PIXELS * V_LINES;

   logic              wb_clk_i = 1'b0;
   logic              wb_rst_i;
   logic [ADDR_W-1:0] wb_adr_i;
   logic [31:0]       wb_dat_i;
   logic [31:0]       wb_dat_o;
   logic              wb_we_i;
   logic [3:0]        wb_sel_i;
   logic              wb_stb_i;
   logic              wb_cyc_i;
   logic              wb_ack_o;
   logic [ADDR_W-1:0] fb_base_i;
   logic              frame_start_i;
   logic              pix_req_i;
   logic [BPP-1:0]    pix_o;
   logic              underrun_o;

   int checks   = 0;
   int failures = 0;
   logic [31:0] model [DEPTH];

   typedef struct {
      logic              we;
      logic [ADDR_W-1:0] adr;
      logic [31:0]       dat;
      logic [3:0]        sel;
      logic              chk;
      logic [31:0]       exp;
   } wb_vec_t;
   wb_vec_t vecs [13];

   vram_scan_wb #(
      .ADDR_W(ADDR_W), .DEPTH(DEPTH), .BPP(BPP), .H_PIXELS(H_PIXELS),
      .V_LINES(V_LINES), .PIXEL_DOUBLE(PIXEL_DOUBLE), .FIFO_DEPTH(FIFO_DEPTH)
   ) u_dut (
      .wb_clk_i(wb_clk_i), .wb_rst_i(wb_rst_i), .wb_adr_i(wb_adr_i), .wb_dat_i(wb_dat_i),
      .wb_dat_o(wb_dat_o), .wb_we_i(wb_we_i), .wb_sel_i(wb_sel_i), .wb_stb_i(wb_stb_i),
      .wb_cyc_i(wb_cyc_i), .wb_ack_o(wb_ack_o), .fb_base_i(fb_base_i),
      .frame_start_i(frame_start_i), .pix_req_i(pix_req_i), .pix_o(pix_o),
      .underrun_o(underrun_o)
   );

   always #5 wb_clk_i = ~wb_clk_i;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s actual=0x%08h required=0x%08h", name, act, exp);
      end
   endtask

   function automatic logic [31:0] model_read(input logic [ADDR_W-1:0] adr);
      return (32'(adr) < DEPTH) ? model[adr] : 32'h0;
   endfunction

   function automatic void model_write(input logic [ADDR_W-1:0] adr, input logic [31:0] dat,
                                       input logic [3:0] sel);
      if (32'(adr) < DEPTH) begin
         for (int n = 0; n < 4; n++) begin
            if (sel[n]) model[adr][8*n +: 8] = dat[8*n +: 8];
         end
      end
   endfunction

   // Displayed pixel k maps to stored line k/H/2 and stored pixel (k%H)/2
   function automatic logic [BPP-1:0] exp_pix(input int unsigned base, input int unsigned k);
      int unsigned line;
      int unsigned q;
      int unsigned word;
      line = k / H_PIXELS;
      q    = (k % H_PIXELS) / 2;
      word = (base + (line / 2) * WPL + q / PPW) % DEPTH;
      return BPP'(model[word] >> (BPP * (q % PPW)));
   endfunction

   task automatic wb_xfer(input string name, input logic we, input logic [ADDR_W-1:0] adr,
                          input logic [31:0] dat, input logic [3:0] sel,
                          input logic chk, input logic [31:0] exp);
      @(negedge wb_clk_i);
      wb_cyc_i = 1'b1; wb_stb_i = 1'b1; wb_we_i = we;
      wb_adr_i = adr; wb_dat_i = dat; wb_sel_i = sel;
      @(posedge wb_clk_i); #1;
      check({name, " ack"}, 32'(wb_ack_o), 32'd1);
      if (chk) check({name, " rdata"}, wb_dat_o, exp);
      @(negedge wb_clk_i);
      wb_cyc_i = 1'b0; wb_stb_i = 1'b0; wb_we_i = 1'b0;
   endtask

   task automatic start_frame(input int unsigned base, input logic with_req);
      @(negedge wb_clk_i);
      frame_start_i = 1'b1; fb_base_i = ADDR_W'(base); pix_req_i = with_req;
      @(negedge wb_clk_i);
      frame_start_i = 1'b0; pix_req_i = 1'b0;
   endtask

   // Called at a negedge; requests pixels first..last-1 with random idle gaps
   task automatic scan_pixels(input string name, input int unsigned base, input int unsigned first,
                              input int unsigned last, input int unsigned max_gap,
                              input logic exp_ur);
      logic [BPP-1:0] e;
      int unsigned gap;
      for (int unsigned k = first; k < last; k++) begin
         pix_req_i = 1'b1;
         @(posedge wb_clk_i); #1;
         e = exp_pix(base, k);
         check($sformatf("%s pix%0d", name, k), 32'(pix_o), 32'(e));
         check($sformatf("%s ur%0d", name, k), 32'(underrun_o), 32'(exp_ur));
         gap = $urandom_range(max_gap, 0);
         for (int unsigned g = 0; g < gap; g++) begin
            @(negedge wb_clk_i); pix_req_i = 1'b0;
            @(posedge wb_clk_i); #1;
            check($sformatf("%s hold%0d", name, k), 32'(pix_o), 32'(e));
         end
         @(negedge wb_clk_i);
      end
      pix_req_i = 1'b0;
   endtask

   initial begin
      logic [ADDR_W-1:0] a;
      logic [31:0]       d;
      logic [31:0]       e;
      logic [3:0]        s;
      logic              w;
      int unsigned       base;

      vecs[0]  = '{1'b1, 8'd5,   32'hDEADBEEF, 4'hF, 1'b0, 32'h0};
      vecs[1]  = '{1'b1, 8'd5,   32'h0000AA00, 4'h2, 1'b1, 32'hDEADBEEF};
      vecs[2]  = '{1'b0, 8'd5,   32'h0,        4'h0, 1'b1, 32'hDEADAAEF};
      vecs[3]  = '{1'b1, 8'd6,   32'h0,        4'hF, 1'b0, 32'h0};
      vecs[4]  = '{1'b1, 8'd6,   32'h12345678, 4'h5, 1'b1, 32'h0};
      vecs[5]  = '{1'b0, 8'd6,   32'h0,        4'h0, 1'b1, 32'h00340078};
      vecs[6]  = '{1'b1, 8'd6,   32'hAB000000, 4'h8, 1'b1, 32'h00340078};
      vecs[7]  = '{1'b0, 8'd6,   32'h0,        4'h0, 1'b1, 32'hAB340078};
      vecs[8]  = '{1'b1, 8'd200, 32'h00001234, 4'hF, 1'b1, 32'h0};
      vecs[9]  = '{1'b0, 8'd200, 32'h0,        4'h0, 1'b1, 32'h0};
      vecs[10] = '{1'b0, 8'd255, 32'h0,        4'h0, 1'b1, 32'h0};
      vecs[11] = '{1'b1, 8'd199, 32'hCAFEF00D, 4'hF, 1'b0, 32'h0};
      vecs[12] = '{1'b0, 8'd199, 32'h0,        4'h0, 1'b1, 32'hCAFEF00D};

      wb_rst_i = 1'b1; wb_adr_i = '0; wb_dat_i = '0; wb_we_i = 1'b0; wb_sel_i = '0;
      wb_stb_i = 1'b0; wb_cyc_i = 1'b0; fb_base_i = '0; frame_start_i = 1'b0; pix_req_i = 1'b0;
      repeat (3) @(negedge wb_clk_i);
      wb_rst_i = 1'b0;
      check("rst ack", 32'(wb_ack_o), 32'd0);
      check("rst dat", wb_dat_o, 32'd0);
      check("rst pix", 32'(pix_o), 32'd0);
      check("rst ur", 32'(underrun_o), 32'd0);

      for (int i = 0; i < 13; i++) begin
         wb_xfer($sformatf("vec%0d", i), vecs[i].we, vecs[i].adr, vecs[i].dat, vecs[i].sel,
                 vecs[i].chk, vecs[i].exp);
      end

      for (int i = 0; i < int'(DEPTH); i++) begin
         d = $urandom;
         wb_xfer($sformatf("fill%0d", i), 1'b1, ADDR_W'(i), d, 4'hF, 1'b0, 32'h0);
         model_write(ADDR_W'(i), d, 4'hF);
      end

      // Strobe held across four cycles: access, forced idle, access, forced idle
      @(negedge wb_clk_i);
      wb_cyc_i = 1'b1; wb_stb_i = 1'b1; wb_we_i = 1'b0; wb_adr_i = 8'd7;
      for (int c = 0; c < 4; c++) begin
         @(posedge wb_clk_i); #1;
         check($sformatf("hold ack c%0d", c), 32'(wb_ack_o), (c % 2 == 0) ? 32'd1 : 32'd0);
         if (c == 0) check("hold rdata", wb_dat_o, model[7]);
      end
      @(negedge wb_clk_i);
      wb_cyc_i = 1'b0; wb_stb_i = 1'b0;

      for (int i = 0; i < 40; i++) begin
         a = ADDR_W'($urandom_range(255, 0));
         d = $urandom;
         s = 4'($urandom_range(15, 0));
         w = 1'($urandom_range(1, 0));
         e = model_read(a);
         wb_xfer($sformatf("rnd%0d", i), w, a, d, s, 1'b1, e);
         if (w) model_write(a, d, s);
      end

      // Frame A: continuous requests after a short lead, then one past the end
      base = $urandom_range(DEPTH - 1, 0);
      start_frame(base, 1'b0);
      repeat (4) @(negedge wb_clk_i);
      scan_pixels("fA", base, 0, NPIX, 0, 1'b0);
      pix_req_i = 1'b1;
      @(posedge wb_clk_i); #1;
      check("past end pix", 32'(pix_o), 32'd0);
      check("past end ur", 32'(underrun_o), 32'd1);
      @(negedge wb_clk_i);
      pix_req_i = 1'b0;

      // Frame B: base near top of RAM wraps; pix_req coincident with frame start is ignored
      base = DEPTH - 3;
      start_frame(base, 1'b1);
      check("fB start ur clr", 32'(underrun_o), 32'd0);
      repeat (4) @(negedge wb_clk_i);
      scan_pixels("fB", base, 0, NPIX, 2, 1'b0);

      // Frame C: request right after frame start underruns, later pixels stay aligned
      base = $urandom_range(DEPTH - 1, 0);
      start_frame(base, 1'b0);
      pix_req_i = 1'b1;
      @(posedge wb_clk_i); #1;
      check("early pix", 32'(pix_o), 32'd0);
      check("early ur", 32'(underrun_o), 32'd1);
      @(negedge wb_clk_i);
      pix_req_i = 1'b0;
      repeat (6) @(negedge wb_clk_i);
      scan_pixels("fC", base, 1, 100, 1, 1'b1);

      wb_rst_i = 1'b1;
      repeat (2) @(negedge wb_clk_i);
      wb_rst_i = 1'b0;
      check("midrst ack", 32'(wb_ack_o), 32'd0);
      check("midrst dat", wb_dat_o, 32'd0);
      check("midrst pix", 32'(pix_o), 32'd0);
      check("midrst ur", 32'(underrun_o), 32'd0);

      base = $urandom_range(DEPTH - 1, 0);
      start_frame(base, 1'b0);
      repeat (4) @(negedge wb_clk_i);
      scan_pixels("fD", base, 0, NPIX, 1, 1'b0);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end
endmodule
